// File: rtl/ad7476a_sample_arbiter.sv
// Round-robin arbiter that shares one AD7476A interface between NUM_REQ clients.
// It issues one conversion per grant, returns the sample with an ack, and aborts a conversion that stalls.
module ad7476a_sample_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    output logic [NUM_REQ-1:0]    ack_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  adc_request_o,
    input  logic [DATA_WIDTH-1:0] adc_data_i,
    input  logic                  adc_data_valid_i
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DELIVER = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      winner_q, winner_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  timeout_d;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]    winner_onehot;

    // Client index base+off, wrapping past NUM_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    endfunction

    // First requesting client searching upward from the round-robin pointer.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && req_i[wrap_add(ptr_q, i)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        data_d    = data_o;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A strobe in the expiry cycle still delivers the sample.
                if (adc_data_valid_i) begin
                    data_d  = adc_data_i;
                    state_d = ST_DELIVER;
                end else if (cnt_q >= CNT_LAST) begin
                    timeout_d = 1'b1;
                    ptr_d     = next_ptr(winner_q);
                    state_d   = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DELIVER: begin
                ptr_d   = next_ptr(winner_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_d;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            winner_q      <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            data_o        <= '0;
            ack_o         <= '0;
            grant_o       <= '0;
            busy_o        <= 1'b0;
            timeout_o     <= 1'b0;
            adc_request_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            data_o        <= data_d;
            ack_o         <= (state_d == ST_DELIVER) ? winner_onehot : '0;
            grant_o       <= (state_d != ST_IDLE) ? winner_onehot : '0;
            busy_o        <= (state_d != ST_IDLE);
            timeout_o     <= timeout_d;
            adc_request_o <= (state_d == ST_ISSUE);
        end
    end

endmodule

// File: tb/tb_ad7476a_sample_arbiter.sv
// Scoreboard bench for ad7476a_sample_arbiter: directed client/ADC traffic, with a monitor
// that matches every ack or timeout pulse against the expected-event queue.
module tb_ad7476a_sample_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 12;
    localparam int unsigned TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NR-1:0] req_i;
    logic [NR-1:0] ack_o;
    logic [DW-1:0] data_o;
    logic [NR-1:0] grant_o;
    logic          busy_o;
    logic          timeout_o;
    logic          adc_request_o;
    logic [DW-1:0] adc_data_i;
    logic          adc_data_valid_i;

    always #5 clk_i = ~clk_i;

    ad7476a_sample_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .ack_o(ack_o),
        .data_o(data_o),
        .grant_o(grant_o),
        .busy_o(busy_o),
        .timeout_o(timeout_o),
        .adc_request_o(adc_request_o),
        .adc_data_i(adc_data_i),
        .adc_data_valid_i(adc_data_valid_i)
    );

    typedef struct packed {
        logic          to;
        logic [NR-1:0] ack;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_pulse(input int n);
        rst_i            = 1'b1;
        req_i            = '0;
        adc_data_valid_i = 1'b0;
        repeat (n) begin
            @(negedge clk_i);
            check("reset_outputs",
                  32'({ack_o, grant_o, busy_o, timeout_o, adc_request_o, data_o}), 32'(0));
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wait_adc_req(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!adc_request_o && cyc < 60);
        if (!adc_request_o) check("adc_request_seen", 32'(0), 32'(1));
    endtask

    task automatic send_sample(input int d, input logic [DW-1:0] s);
        repeat (d) @(negedge clk_i);
        adc_data_i       = s;
        adc_data_valid_i = 1'b1;
        @(negedge clk_i);
        adc_data_valid_i = 1'b0;
    endtask

    task automatic serve(input logic [NR-1:0] who, input logic [DW-1:0] s, input int d);
        int cyc;
        int n;
        exp_q.push_back('{1'b0, who, s});
        wait_adc_req(cyc);
        check("grant", 32'(grant_o), 32'(who));
        send_sample(d, s);
        n = 0;
        while (ack_o == '0 && n < 5) begin
            @(negedge clk_i);
            n++;
        end
        if (ack_o == '0) check("ack_seen", 32'(0), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int            cyc;
        logic [DW-1:0] samp [8];
        samp = '{12'h111, 12'h222, 12'h333, 12'h444, 12'hA55, 12'hB66, 12'hC77, 12'hD88};

        rst_i            = 1'b1;
        req_i            = '0;
        adc_data_i       = '0;
        adc_data_valid_i = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk_i);
                if (rst_i) begin
                    prev_req = 1'b0;
                end else begin
                    if (adc_request_o) check("adc_request_single", 32'(prev_req), 32'(0));
                    prev_req = adc_request_o;
                    if (ack_o != '0 || timeout_o) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_event", 32'({ack_o, timeout_o}), 32'(0));
                        end else begin
                            e = exp_q.pop_front();
                            check("ack_or_timeout",
                                  32'({ack_o, timeout_o, (e.to ? 12'h000 : data_o)}),
                                  32'({e.ack, e.to, (e.to ? 12'h000 : e.data)}));
                        end
                    end
                end
            end
        join_none

        reset_pulse(3);

        // Single client, check request latency and delivered sample.
        req_i = 4'b0001;
        exp_q.push_back('{1'b0, 4'b0001, 12'hBA5});
        wait_adc_req(cyc);
        check("req_to_adc_latency", 32'(cyc), 32'(1));
        check("busy_in_issue", 32'(busy_o), 32'(1));
        check("grant_single", 32'(grant_o), 32'(4'b0001));
        send_sample(2, 12'hBA5);
        check("ack_single", 32'(ack_o), 32'(4'b0001));
        req_i = '0;
        repeat (2) @(negedge clk_i);

        // Fresh pointer, all clients requesting: strict rotation.
        reset_pulse(2);
        req_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            serve(4'(1 << (k % 4)), samp[k], 1 + (k % 3));
        end
        req_i = '0;
        repeat (2) @(negedge clk_i);

        // Stalled conversion for client 1, then the pointer must favour client 2.
        req_i = 4'b0010;
        exp_q.push_back('{1'b1, 4'b0000, 12'h000});
        wait_adc_req(cyc);
        req_i = '0;
        cyc   = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!timeout_o && cyc < 40);
        check("timeout_latency", 32'(cyc), 32'(TO + 1));
        check("busy_after_timeout", 32'(busy_o), 32'(0));
        req_i = 4'b0111;
        serve(4'b0100, 12'h3C3, 3);
        req_i = '0;
        repeat (2) @(negedge clk_i);

        // Valid in the watchdog expiry cycle: data wins.
        req_i = 4'b0001;
        serve(4'b0001, 12'h7E1, TO);
        req_i = '0;
        @(negedge clk_i);
        check("no_timeout_after_race", 32'(timeout_o), 32'(0));
        repeat (2) @(negedge clk_i);

        // Reset during WAIT_DATA drops the transaction silently.
        req_i = 4'b1000;
        wait_adc_req(cyc);
        check("grant_before_reset", 32'(grant_o), 32'(4'b1000));
        repeat (3) @(negedge clk_i);
        reset_pulse(2);
        req_i = 4'b0100;
        serve(4'b0100, 12'h5A5, 1);
        req_i = '0;
        repeat (3) @(negedge clk_i);

        // Stray valid strobe while idle.
        adc_data_i       = 12'h123;
        adc_data_valid_i = 1'b1;
        @(negedge clk_i);
        adc_data_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("data_hold_stray_valid", 32'(data_o), 32'(12'h5A5));
        check("idle_after_stray_valid", 32'(busy_o), 32'(0));

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
